// File: rtl/enc_buffer_if.sv
// Handshake/bus bundle between the source, the enc_buffer and the encoder formatter.
// buf_underrun_cnt exists only when ENC_BUF_UNDERRUN_CNT_EN is defined.
interface enc_buffer_if #(
  parameter int ENC_SYM_NUM = 4,
  parameter int EGF_ORDER   = 8,
  parameter int BUF_DEPTH   = 3*ENC_SYM_NUM
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0]     in_data;
  logic [$clog2(ENC_SYM_NUM+1)-1:0]          con_take;
  logic [$clog2(ENC_SYM_NUM+1)-1:0]          buf_request;
  logic [2*ENC_SYM_NUM-2:0][EGF_ORDER-1:0]   buf_data;
  logic [$clog2(BUF_DEPTH+1)-1:0]            buf_fill;
  logic                                      buf_underrun;
`ifdef ENC_BUF_UNDERRUN_CNT_EN
  logic [15:0]                               buf_underrun_cnt;
`endif

  modport slave (
    input  in_valid, in_data, con_take,
    output in_ready, buf_request, buf_data, buf_fill, buf_underrun
`ifdef ENC_BUF_UNDERRUN_CNT_EN
    , output buf_underrun_cnt
`endif
  );

  modport master (
    output in_valid, in_data, con_take,
    input  in_ready, buf_request, buf_data, buf_fill, buf_underrun
`ifdef ENC_BUF_UNDERRUN_CNT_EN
    , input buf_underrun_cnt
`endif
  );
endinterface

// File: rtl/enc_buffer.sv
// Shift-register staging FIFO feeding the encoder formatter with a window of the oldest symbols.
// Optional refused-take counter enabled by ENC_BUF_UNDERRUN_CNT_EN.
module enc_buffer #(
  parameter int ENC_SYM_NUM = 4,
  parameter int EGF_ORDER   = 8,
  parameter int BUF_DEPTH   = 3*ENC_SYM_NUM
) (
  input  logic        clk,
  input  logic        rst_n,
  enc_buffer_if.slave bus
);
  localparam int FW = $clog2(BUF_DEPTH+1);
  localparam int AW = FW + 1;

  logic [BUF_DEPTH-1:0][EGF_ORDER-1:0] r_mem;
  logic [FW-1:0]                       r_fill;
  logic                                r_underrun;

  logic [BUF_DEPTH-1:0][EGF_ORDER-1:0] w_mem_nxt;
  logic [AW-1:0]                       w_fill_ext;
  logic [AW-1:0]                       w_take_ext;
  logic [AW-1:0]                       w_k_ext;
  logic [AW-1:0]                       w_add;
  logic [FW-1:0]                       w_base;
  logic [FW-1:0]                       w_fill_nxt;
  logic [$clog2(ENC_SYM_NUM+1)-1:0]    w_k;
  logic                                w_refuse;
  logic                                w_ready;
  logic                                w_push;

  assign w_fill_ext = AW'(r_fill);
  assign w_take_ext = AW'(bus.con_take);
  assign w_refuse   = w_take_ext > w_fill_ext;
  assign w_k        = w_refuse ? '0 : bus.con_take;
  assign w_k_ext    = AW'(w_k);
  // Ready already credits this cycle's release so a full buffer can take and push together.
  assign w_ready    = (w_fill_ext - w_k_ext + AW'(ENC_SYM_NUM)) <= AW'(BUF_DEPTH);
  assign w_push     = bus.in_valid && w_ready;
  assign w_base     = FW'(w_fill_ext - w_k_ext);
  assign w_add      = w_push ? AW'(ENC_SYM_NUM) : '0;
  assign w_fill_nxt = FW'(w_fill_ext - w_k_ext + w_add);

  always_comb begin
    w_mem_nxt = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (i >= int'(w_k)) w_mem_nxt[i] = r_mem[i - int'(w_k)];
    end
    // Earliest symbol of the beat lands directly below the surviving contents.
    if (w_push) begin
      for (int t = 0; t < ENC_SYM_NUM; t++) begin
        w_mem_nxt[BUF_DEPTH-1-int'(w_base)-t] = bus.in_data[ENC_SYM_NUM-1-t];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem      <= '0;
      r_fill     <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_mem  <= w_mem_nxt;
      r_fill <= w_fill_nxt;
      if (w_refuse) r_underrun <= 1'b1;
    end
  end

`ifdef ENC_BUF_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun_cnt <= '0;
    end else if (w_refuse && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign bus.buf_underrun_cnt = r_underrun_cnt;
`endif

  assign bus.in_ready     = w_ready;
  assign bus.buf_request  = w_k;
  assign bus.buf_data     = r_mem[BUF_DEPTH-1 -: 2*ENC_SYM_NUM-1];
  assign bus.buf_fill     = r_fill;
  assign bus.buf_underrun = r_underrun;
endmodule
